// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
// Contents:
//   mem_state_e     - controller state encoding (IDLE/LOW/HIGH/DONE)
//   DMEM_BASE_ADDR  - byte address that maps to SRAM word 0
//   SRAM_DW         - SRAM data width (bits)
//   SRAM_AW         - default SRAM address width (half-word units)
//   wait_cnt_width  - width of the per-phase wait counter
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int unsigned DMEM_BASE_ADDR = 32'd1024;
  localparam int unsigned SRAM_DW        = 32'd16;
  localparam int unsigned SRAM_AW        = 32'd18;

  // Counter must hold 0..wait_cycles and never collapse to zero bits.
  function automatic int unsigned wait_cnt_width(input int unsigned wait_cycles);
    if (wait_cycles == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(wait_cycles + 32'd1);
    end
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter for the SRAM controller.
// Counts 0..WAIT_CYCLES and saturates there; `last` flags the final cycle
// of a phase. `clear` restarts the count (asserted on every phase change).
// Ports:
//   clk   - clock
//   rst   - synchronous, active-high reset
//   clear - restart counting from zero on the next edge
//   last  - counter equals WAIT_CYCLES
module sram_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 32'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int unsigned CW = wait_cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_VAL = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] ONE_VAL  = CW'(32'd1);

  logic [CW-1:0] cnt_r;

  // Wait counter: clear on phase change, count up, saturate at LAST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != LAST_VAL) begin
      cnt_r <= cnt_r + ONE_VAL;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == LAST_VAL);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data memory controller for an external 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two half-word accesses (low half first),
// each lasting WAIT_CYCLES+1 cycles. `ready` is low while an access is in
// flight so the pipeline can freeze on ~ready.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rd_en, wr_en      - MEM-stage read/write requests (write wins if both)
//   address, st_val   - byte address and store data (latched in IDLE)
//   read_data         - load result, valid with ready=1 after a read
//   ready             - 1 = idle with no request, or access completing
//   sram_addr         - SRAM half-word address
//   sram_dq_out/_oe   - write data and bus drive enable
//   sram_dq_in        - read data from SRAM
//   sram_we_n/_oe_n   - active-low write / output enables
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 32'd1,
  parameter int unsigned SRAM_AW     = mem_ctrl_pkg::SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        st_val,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned IW = SRAM_AW - 32'd1;
  localparam logic [31:0] BASE_VEC = 32'(BASE_ADDR);

  mem_state_e      state_r;
  mem_state_e      next_state_s;
  logic            req_s;
  logic            last_s;
  logic            clear_s;
  logic            is_write_r;
  logic [IW-1:0]   idx_r;
  logic [31:0]     st_val_r;
  logic [31:0]     offset_s;
  logic [IW-1:0]   idx_new_s;

  // Effective transaction attributes: live inputs while launching from IDLE,
  // latched copies afterwards. Lets the output registers line up with state.
  logic            eff_write_s;
  logic [IW-1:0]   eff_idx_s;
  logic [31:0]     eff_st_s;

  logic [SRAM_AW-1:0] nxt_addr_s;
  logic [15:0]        nxt_dq_out_s;
  logic               nxt_dq_oe_s;
  logic               nxt_we_n_s;
  logic               nxt_oe_n_s;

  assign req_s     = rd_en | wr_en;
  assign offset_s  = address - BASE_VEC;
  // Word index wraps modulo 2^(SRAM_AW-1); out-of-range addresses alias.
  assign idx_new_s = offset_s[SRAM_AW:2];

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .last  (last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          next_state_s = LOW;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          next_state_s = HIGH;
        end else begin
          next_state_s = LOW;
        end
      end
      HIGH: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = HIGH;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output logic: ready, counter clear and next values of the SRAM pins.
  always_comb begin
    ready        = 1'b0;
    clear_s      = 1'b1;
    eff_write_s  = is_write_r;
    eff_idx_s    = idx_r;
    eff_st_s     = st_val_r;
    nxt_addr_s   = sram_addr;
    nxt_dq_out_s = 16'h0000;
    nxt_dq_oe_s  = 1'b0;
    nxt_we_n_s   = 1'b1;
    nxt_oe_n_s   = 1'b1;

    case (state_r)
      IDLE: begin
        ready       = ~req_s;
        clear_s     = 1'b1;
        eff_write_s = wr_en;
        eff_idx_s   = idx_new_s;
        eff_st_s    = st_val;
      end
      LOW: begin
        ready   = 1'b0;
        clear_s = last_s;
      end
      HIGH: begin
        ready   = 1'b0;
        clear_s = last_s;
      end
      DONE: begin
        ready   = 1'b1;
        clear_s = 1'b1;
      end
      default: begin
        ready   = 1'b0;
        clear_s = 1'b1;
      end
    endcase

    case (next_state_s)
      LOW: begin
        nxt_addr_s = {eff_idx_s, 1'b0};
        if (eff_write_s) begin
          nxt_dq_out_s = eff_st_s[15:0];
          nxt_dq_oe_s  = 1'b1;
          nxt_we_n_s   = 1'b0;
        end else begin
          nxt_oe_n_s   = 1'b0;
        end
      end
      HIGH: begin
        nxt_addr_s = {eff_idx_s, 1'b1};
        if (eff_write_s) begin
          nxt_dq_out_s = eff_st_s[31:16];
          nxt_dq_oe_s  = 1'b1;
          nxt_we_n_s   = 1'b0;
        end else begin
          nxt_oe_n_s   = 1'b0;
        end
      end
      default: begin
        nxt_addr_s = sram_addr;
      end
    endcase
  end

  // Transaction latch: capture direction, index and store data on launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write_r <= 1'b0;
      idx_r      <= {IW{1'b0}};
      st_val_r   <= 32'h0000_0000;
    end else if ((state_r == IDLE) && req_s) begin
      is_write_r <= wr_en;
      idx_r      <= idx_new_s;
      st_val_r   <= st_val;
    end else begin
      is_write_r <= is_write_r;
      idx_r      <= idx_r;
      st_val_r   <= st_val_r;
    end
  end

  // Registered SRAM pins, computed from the next state so they track it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr   <= {SRAM_AW{1'b0}};
      sram_dq_out <= 16'h0000;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      sram_addr   <= nxt_addr_s;
      sram_dq_out <= nxt_dq_out_s;
      sram_dq_oe  <= nxt_dq_oe_s;
      sram_we_n   <= nxt_we_n_s;
      sram_oe_n   <= nxt_oe_n_s;
    end
  end

  // Read capture on the last wait cycle of each phase; writes leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'h0000_0000;
    end else if (!is_write_r && last_s && (state_r == LOW)) begin
      read_data[15:0] <= sram_dq_in;
    end else if (!is_write_r && last_s && (state_r == HIGH)) begin
      read_data[31:16] <= sram_dq_in;
    end else begin
      read_data <= read_data;
    end
  end

endmodule
